frame_capture_ctrl: RTL and testbench

- Frame sequencer between the camera AXI4-Stream output (24-bit RGB, tuser=SOF, tlast=EOL) and the DDR DMA S2MM slave.
- Arms the camera capture and aligns the stream to a frame start.
- Gates single, N-frame or continuous capture, checks frame geometry, and reports status and errors to software registers.

---
 rtl/frame_capture_ctrl.sv | 176 +++++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_ctrl.sv
// Frame sequencer between the camera AXI4-Stream and the DMA S2MM slave.
// Aligns to SOF, gates single/N-frame/continuous capture, checks geometry and reports status.
//
// state    | meaning
// IDLE     | not capturing; stream accepted and discarded
// WAIT_SOF | capture armed; junk dropped until a tuser beat starts a frame
// STREAM   | zero-latency pass-through of the frame, geometry checked per beat
module frame_capture_ctrl #(
    parameter int          H_ACTIVE       = 640,
    parameter int          V_ACTIVE       = 480,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    input  logic        cfg_continuous,
    input  logic [15:0] cfg_num_frames,
    output logic        o_start_capture,
    input  logic [23:0] s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    input  logic        s_tuser,
    output logic        s_tready,
    output logic [23:0] m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic        m_tuser,
    input  logic        m_tready,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [15:0] o_frames_done,
    output logic        o_err_short,
    output logic        o_err_long,
    output logic        o_err_sof,
    output logic        o_timeout
);

    localparam int PW = $clog2(H_ACTIVE + 2);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam logic [PW-1:0] H_LAST    = PW'(H_ACTIVE - 1);
    localparam logic [PW-1:0] PIX_MAX   = PW'(H_ACTIVE + 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, STREAM} state_t;

    state_t        state, state_nxt;
    logic          rst_meta, rst_n;
    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;
    logic [23:0]   to_cnt, to_next;
    logic          cont_mode, stop_pending;
    logic [15:0]   num_frames, new_count;
    logic          fwd, beat, sof_beat, frame_end, last_frame, to_clear, timeout_hit;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    always_comb begin
        fwd      = 1'b0;
        s_tready = 1'b1;
        case (state)
            WAIT_SOF: if (s_tuser) begin
                fwd      = 1'b1;
                s_tready = m_tready;
            end
            STREAM: begin
                fwd      = 1'b1;
                s_tready = m_tready;
            end
            default: ;
        endcase
    end

    assign m_tvalid = fwd & s_tvalid;
    assign m_tdata  = fwd ? s_tdata : 24'd0;
    assign m_tlast  = fwd & s_tlast;
    assign m_tuser  = fwd & s_tuser;

    assign beat        = s_tvalid & s_tready;
    assign sof_beat    = beat & s_tuser & (state != IDLE);
    assign frame_end   = (state == STREAM) & beat & s_tlast & ~s_tuser & (line_cnt == LINE_LAST);
    assign new_count   = o_frames_done + 16'd1;
    assign last_frame  = ~cont_mode | stop_pending | cfg_stop |
                         ((num_frames != 16'd0) & (new_count == num_frames));
    // DMA backpressure in STREAM holds the watchdog off, it is not a stalled camera.
    assign to_clear    = beat | ((state == STREAM) & ~m_tready);
    assign to_next     = to_cnt + 24'd1;
    assign timeout_hit = (state != IDLE) & ~to_clear & (to_next == TIMEOUT_CYCLES);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cfg_start && !cfg_stop) state_nxt = WAIT_SOF;
            WAIT_SOF: if (cfg_stop || timeout_hit) state_nxt = IDLE;
                      else if (sof_beat)           state_nxt = STREAM;
            STREAM:   if (timeout_hit)             state_nxt = IDLE;
                      else if (frame_end)          state_nxt = last_frame ? IDLE : WAIT_SOF;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pix_cnt       <= '0;
            line_cnt      <= '0;
            to_cnt        <= '0;
            cont_mode     <= 1'b0;
            num_frames    <= '0;
            stop_pending  <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frames_done <= '0;
            o_err_short   <= 1'b0;
            o_err_long    <= 1'b0;
            o_err_sof     <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_frame_done <= frame_end;
            if (state == IDLE) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
                to_cnt   <= '0;
                if (cfg_start && !cfg_stop) begin
                    cont_mode     <= cfg_continuous;
                    num_frames    <= cfg_num_frames;
                    stop_pending  <= 1'b0;
                    o_frames_done <= '0;
                    o_err_short   <= 1'b0;
                    o_err_long    <= 1'b0;
                    o_err_sof     <= 1'b0;
                    o_timeout     <= 1'b0;
                end
            end else begin
                if (to_clear || timeout_hit) to_cnt <= '0;
                else                         to_cnt <= to_next;
                if (timeout_hit) o_timeout <= 1'b1;
                if (cfg_stop && state == STREAM) stop_pending <= 1'b1;

                if (sof_beat) begin
                    // A restart mid-frame abandons the partial frame uncounted.
                    if (state == STREAM && (pix_cnt != '0 || line_cnt != '0)) o_err_sof <= 1'b1;
                    pix_cnt  <= PW'(1);
                    line_cnt <= '0;
                end else if (state == STREAM && beat) begin
                    if (s_tlast) begin
                        if (pix_cnt < H_LAST) o_err_short <= 1'b1;
                        if (pix_cnt > H_LAST) o_err_long  <= 1'b1;
                        pix_cnt <= '0;
                        if (line_cnt == LINE_LAST) begin
                            line_cnt      <= '0;
                            o_frames_done <= new_count;
                        end else begin
                            line_cnt <= line_cnt + 1'b1;
                        end
                    end else if (pix_cnt != PIX_MAX) begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign o_busy          = (state != IDLE);
    assign o_start_capture = (state != IDLE);

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl with a 4x3 frame and a 50-cycle timeout.
module tb_frame_capture_ctrl;

    localparam int H = 4;
    localparam int V = 3;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_start = 1'b0, cfg_stop = 1'b0, cfg_continuous = 1'b0;
    logic [15:0] cfg_num_frames = 16'd0;
    logic        o_start_capture;
    logic [23:0] s_tdata = 24'd0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic        s_tready;
    logic [23:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tuser;
    logic        m_tready = 1'b1;
    logic        o_busy, o_frame_done;
    logic [15:0] o_frames_done;
    logic        o_err_short, o_err_long, o_err_sof, o_timeout;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          fd_cnt = 0;
    int          mirror_err = 0;
    bit          tog_en = 1'b0;
    logic [25:0] fwd_q[$];
    logic [25:0] exp_q[$];

    always #5 aclk = ~aclk;

    frame_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .TIMEOUT_CYCLES(24'd50)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_continuous(cfg_continuous), .cfg_num_frames(cfg_num_frames),
        .o_start_capture(o_start_capture),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .m_tready(m_tready),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_frames_done(o_frames_done),
        .o_err_short(o_err_short), .o_err_long(o_err_long),
        .o_err_sof(o_err_sof), .o_timeout(o_timeout)
    );

    // Inputs change 1 time unit after posedge, so the negedge sees a settled handshake.
    always @(negedge aclk) begin
        if (m_tvalid && m_tready) fwd_q.push_back({m_tuser, m_tlast, m_tdata});
        if (o_frame_done) fd_cnt++;
        if (m_tvalid && (s_tready !== m_tready)) mirror_err++;
    end

    initial forever begin
        @(posedge aclk);
        #1;
        if (tog_en) m_tready = ~m_tready;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    function automatic void gen_frame(input int fid);
        for (int ln = 0; ln < V; ln++)
            for (int p = 0; p < H; p++)
                exp_q.push_back({(ln == 0 && p == 0), (p == H - 1), 8'(fid), 8'(ln), 8'(p)});
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic beat(input logic [23:0] d, input logic last, input logic user);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        s_tdata = d; s_tlast = last; s_tuser = user; s_tvalid = 1'b1;
        while (!acc) begin
            @(negedge aclk);
            acc = s_tready;
            @(posedge aclk);
            #1;
            n++;
            if (!acc && n > 200) begin
                tests_run++; tests_failed++;
                $display("FAIL beat_accept: data %h not accepted after %0d cycles, want accepted", d, n);
                break;
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    endtask

    task automatic send_line(input int fid, input int ln, input int npix, input bit sof);
        for (int p = 0; p < npix; p++)
            beat({8'(fid), 8'(ln), 8'(p)}, (p == npix - 1), (sof && p == 0));
    endtask

    task automatic send_frame(input int fid);
        for (int ln = 0; ln < V; ln++) send_line(fid, ln, H, (ln == 0));
    endtask

    task automatic pulse_start(input bit cont, input logic [15:0] num, input bit with_stop);
        cfg_start = 1'b1; cfg_continuous = cont; cfg_num_frames = num; cfg_stop = with_stop;
        @(posedge aclk);
        #1;
        cfg_start = 1'b0; cfg_stop = 1'b0;
    endtask

    task automatic pulse_stop();
        cfg_stop = 1'b1;
        @(posedge aclk);
        #1;
        cfg_stop = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        m_tready = 1'b1;
        #2;
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        tests_run++; if (s_tready !== 1'b1) begin tests_failed++; $display("FAIL reset_s_tready: got %b want 1", s_tready); end
        tests_run++; if (m_tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_tvalid: got %b want 0", m_tvalid); end
        tests_run++; if (o_frames_done !== 16'd0) begin tests_failed++; $display("FAIL reset_frames: got %0d want 0", o_frames_done); end
        tests_run++; if ({o_err_short, o_err_long, o_err_sof, o_timeout, o_start_capture, o_frame_done} !== 6'b0) begin
            tests_failed++; $display("FAIL reset_flags: got %b want 000000",
                {o_err_short, o_err_long, o_err_sof, o_timeout, o_start_capture, o_frame_done}); end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cycles(3);
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_release_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_single();
        fwd_q.delete(); exp_q.delete(); fd_cnt = 0;
        pulse_start(1'b0, 16'd0, 1'b0);
        tests_run++; if (o_busy !== 1'b1 || o_start_capture !== 1'b1) begin
            tests_failed++; $display("FAIL single_armed: busy %b start %b want 1 1", o_busy, o_start_capture); end
        beat(24'hEE0000, 1'b0, 1'b0);
        beat(24'hEE0001, 1'b1, 1'b0);
        send_frame(1);
        cycles(2);
        gen_frame(1);
        tests_run++; if (fwd_q.size() != 12) begin tests_failed++; $display("FAIL single_count: got %0d beats want 12", fwd_q.size()); end
        for (int i = 0; i < exp_q.size() && i < fwd_q.size(); i++) begin
            tests_run++; if (fwd_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL single_data[%0d]: got %h want %h", i, fwd_q[i], exp_q[i]); end
        end
        tests_run++; if (fd_cnt != 1) begin tests_failed++; $display("FAIL single_done_pulse: got %0d want 1", fd_cnt); end
        tests_run++; if (o_frames_done !== 16'd1) begin tests_failed++; $display("FAIL single_frames: got %0d want 1", o_frames_done); end
        tests_run++; if (o_busy !== 1'b0 || o_start_capture !== 1'b0) begin
            tests_failed++; $display("FAIL single_idle: busy %b start %b want 0 0", o_busy, o_start_capture); end
    endtask

    task automatic test_continuous();
        fwd_q.delete(); exp_q.delete(); fd_cnt = 0;
        pulse_start(1'b1, 16'd2, 1'b0);
        send_frame(8'h11);
        send_frame(8'h12);
        send_frame(8'h13);
        cycles(2);
        gen_frame(8'h11);
        gen_frame(8'h12);
        tests_run++; if (fwd_q.size() != 24) begin tests_failed++; $display("FAIL cont_count: got %0d beats want 24", fwd_q.size()); end
        for (int i = 0; i < exp_q.size() && i < fwd_q.size(); i++) begin
            tests_run++; if (fwd_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL cont_data[%0d]: got %h want %h", i, fwd_q[i], exp_q[i]); end
        end
        tests_run++; if (o_frames_done !== 16'd2) begin tests_failed++; $display("FAIL cont_frames: got %0d want 2", o_frames_done); end
        tests_run++; if (fd_cnt != 2) begin tests_failed++; $display("FAIL cont_done_pulses: got %0d want 2", fd_cnt); end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL cont_idle: got %b want 0", o_busy); end
    endtask

    task automatic test_backpressure();
        fwd_q.delete(); exp_q.delete(); mirror_err = 0;
        tog_en = 1'b1;
        pulse_start(1'b0, 16'd0, 1'b0);
        send_frame(8'h21);
        cycles(2);
        tog_en = 1'b0;
        cycles(1);
        m_tready = 1'b1;
        gen_frame(8'h21);
        tests_run++; if (fwd_q.size() != 12) begin tests_failed++; $display("FAIL bp_count: got %0d beats want 12", fwd_q.size()); end
        for (int i = 0; i < exp_q.size() && i < fwd_q.size(); i++) begin
            tests_run++; if (fwd_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL bp_data[%0d]: got %h want %h", i, fwd_q[i], exp_q[i]); end
        end
        tests_run++; if (mirror_err != 0) begin tests_failed++; $display("FAIL bp_mirror: got %0d violations want 0", mirror_err); end
        tests_run++; if (o_timeout !== 1'b0) begin tests_failed++; $display("FAIL bp_timeout: got %b want 0", o_timeout); end
        tests_run++; if (o_frames_done !== 16'd1) begin tests_failed++; $display("FAIL bp_frames: got %0d want 1", o_frames_done); end
    endtask

    task automatic test_geometry();
        pulse_start(1'b0, 16'd0, 1'b0);
        send_line(8'h31, 0, 3, 1'b1);
        send_line(8'h31, 1, 4, 1'b0);
        send_line(8'h31, 2, 4, 1'b0);
        cycles(2);
        tests_run++; if ({o_err_short, o_err_long, o_err_sof} !== 3'b100) begin
            tests_failed++; $display("FAIL geo_short: got %b want 100", {o_err_short, o_err_long, o_err_sof}); end

        pulse_start(1'b0, 16'd0, 1'b0);
        send_line(8'h32, 0, 5, 1'b1);
        send_line(8'h32, 1, 4, 1'b0);
        send_line(8'h32, 2, 4, 1'b0);
        cycles(2);
        tests_run++; if ({o_err_short, o_err_long, o_err_sof} !== 3'b010) begin
            tests_failed++; $display("FAIL geo_long: got %b want 010", {o_err_short, o_err_long, o_err_sof}); end

        pulse_start(1'b0, 16'd0, 1'b0);
        beat(24'h330000, 1'b0, 1'b1);
        beat(24'h330001, 1'b0, 1'b0);
        send_line(8'h34, 0, 4, 1'b1);
        tests_run++; if (o_err_sof !== 1'b1) begin tests_failed++; $display("FAIL geo_sof_flag: got %b want 1", o_err_sof); end
        tests_run++; if (o_frames_done !== 16'd0) begin tests_failed++; $display("FAIL geo_sof_partial: got %0d want 0", o_frames_done); end
        send_line(8'h34, 1, 4, 1'b0);
        send_line(8'h34, 2, 4, 1'b0);
        cycles(2);
        tests_run++; if (o_frames_done !== 16'd1) begin tests_failed++; $display("FAIL geo_sof_frames: got %0d want 1", o_frames_done); end
        tests_run++; if ({o_err_short, o_err_long} !== 2'b00) begin
            tests_failed++; $display("FAIL geo_sof_clean: got %b want 00", {o_err_short, o_err_long}); end
    endtask

    task automatic test_stop_timeout();
        fwd_q.delete();
        pulse_start(1'b1, 16'd0, 1'b0);
        send_line(8'h41, 0, 4, 1'b1);
        pulse_stop();
        tests_run++; if (o_busy !== 1'b1) begin tests_failed++; $display("FAIL stop_inflight: got busy %b want 1", o_busy); end
        send_line(8'h41, 1, 4, 1'b0);
        send_line(8'h41, 2, 4, 1'b0);
        cycles(2);
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL stop_idle: got busy %b want 0", o_busy); end
        tests_run++; if (o_frames_done !== 16'd1) begin tests_failed++; $display("FAIL stop_frames: got %0d want 1", o_frames_done); end
        send_frame(8'h42);
        tests_run++; if (fwd_q.size() != 12) begin tests_failed++; $display("FAIL stop_discard: got %0d beats want 12", fwd_q.size()); end

        pulse_start(1'b0, 16'd0, 1'b0);
        cycles(40);
        tests_run++; if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin
            tests_failed++; $display("FAIL timeout_early: timeout %b busy %b want 0 1", o_timeout, o_busy); end
        cycles(15);
        tests_run++; if (o_timeout !== 1'b1 || o_busy !== 1'b0 || o_start_capture !== 1'b0) begin
            tests_failed++; $display("FAIL timeout_hit: timeout %b busy %b start %b want 1 0 0", o_timeout, o_busy, o_start_capture); end

        pulse_start(1'b0, 16'd0, 1'b0);
        tests_run++; if ({o_err_short, o_err_long, o_err_sof, o_timeout} !== 4'b0000 || o_busy !== 1'b1) begin
            tests_failed++; $display("FAIL restart_clear: flags %b busy %b want 0000 1",
                {o_err_short, o_err_long, o_err_sof, o_timeout}, o_busy); end
        pulse_stop();
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL wait_sof_stop: got busy %b want 0", o_busy); end

        pulse_start(1'b0, 16'd0, 1'b1);
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL start_with_stop: got busy %b want 0", o_busy); end
    endtask

    task automatic test_async_reset();
        pulse_start(1'b1, 16'd0, 1'b0);
        send_frame(8'h51);
        beat(24'h520000, 1'b0, 1'b1);
        beat(24'h520001, 1'b0, 1'b0);
        s_tdata = 24'h520002; s_tvalid = 1'b1;
        m_tready = 1'b0;
        @(negedge aclk);
        tests_run++; if (m_tvalid !== 1'b1 || o_frames_done !== 16'd1 || o_busy !== 1'b1) begin
            tests_failed++; $display("FAIL areset_pre: m_tvalid %b frames %0d busy %b want 1 1 1", m_tvalid, o_frames_done, o_busy); end
        #2;
        aresetn = 1'b0;
        #1;
        tests_run++; if (m_tvalid !== 1'b0 || m_tdata !== 24'd0) begin
            tests_failed++; $display("FAIL areset_m: m_tvalid %b m_tdata %h want 0 000000", m_tvalid, m_tdata); end
        tests_run++; if (s_tready !== 1'b1 || o_busy !== 1'b0 || o_start_capture !== 1'b0) begin
            tests_failed++; $display("FAIL areset_ctrl: s_tready %b busy %b start %b want 1 0 0", s_tready, o_busy, o_start_capture); end
        tests_run++; if (o_frames_done !== 16'd0) begin tests_failed++; $display("FAIL areset_frames: got %0d want 0", o_frames_done); end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cycles(3);
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL areset_after: got busy %b want 0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_backpressure();
        test_geometry();
        test_stop_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
